uart_byte_rx: RTL
=================

Name: uart_byte_rx

Overview:
- 8N1 UART receiver that feeds the serial command processor.
- Converts the asynchronous serial input pin into one-cycle rxReady strobes with a parallel rxData byte.
- Sits between the board's serial RX pin and the command processor's rxReady/rxData inputs.
- Also reports framing errors, line-break condition and a busy flag for debug/LED use.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200). Must be >= 8.
- BREAK_BITS, 20, consecutive low bit-times that declare a line break.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line, idle high
- rxReady  output  1  one-cycle strobe: rxData holds a newly received valid byte
- rxData  output  8  last correctly framed byte, LSB received first
- framingError  output  1  one-cycle strobe: stop bit sampled low
- lineBreak  output  1  level: line held low >= BREAK_BITS bit-times
- rxBusy  output  1  level: high while a frame is in progress (not IDLE)

Behaviour:
- Input sync: rx passes through a 2-FF synchronizer giving rx_s. Both FFs reset to 1. Only rx_s is used internally.
- HALF = CLKS_PER_BIT/2, integer floor. Bit counter is 3 bits; cycle counter is wide enough for CLKS_PER_BIT-1.
- Reset values: rxReady=0, rxData=8'h00, framingError=0, lineBreak=0, rxBusy=0, state=IDLE, counters=0. Reset mid-frame aborts the frame with no strobe.
- States:
  - IDLE: wait for a start bit. If rx_s==0, go to START with cnt=0.
  - START: cnt++. At cnt==HALF-1, re-check rx_s.
    - rx_s==1 (false start/glitch): return to IDLE, no strobe.
    - rx_s==0: go to DATA with cnt=0, bit=0.
  - DATA: cnt++. At cnt==CLKS_PER_BIT-1, shift rx_s into a shift register at bit position [bit] (LSB first) and set cnt=0.
    - After bit 7: go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1: on the next cycle rxData=shift register, rxReady=1 for exactly one cycle; go to IDLE.
    - rx_s==0: framingError=1 for one cycle, rxData unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. In this state a low-time counter (in bit-times, counted from the start edge) that reaches BREAK_BITS sets lineBreak=1. lineBreak clears on the first cycle rx_s==1.
- rxBusy=1 in START, DATA, STOP and WAIT_HIGH.
- Returning to IDLE at mid-stop-bit is required: back-to-back frames with exactly one stop bit must be received without loss.
- Latency: rxReady asserts 2 (sync) + HALF + 9*CLKS_PER_BIT + 1 cycles after the first clk edge that samples rx low, ±1 cycle.
- rxData is stable between strobes. The consumer samples it only on rxReady; there is no backpressure, and a byte not taken on its strobe is lost.
- rxReady and framingError are never high in the same cycle.

Test Plan:
- CLKS_PER_BIT=16, send 8'h0A (start, 0,1,0,1,0,0,0,0, stop) -> single rxReady pulse 155±1 cycles after falling edge, rxData=8'h0A, framingError stays 0.
- Back-to-back frames 8'h0E, 8'h01, 8'hFF with one stop bit each, no idle gap -> three rxReady pulses exactly 160 cycles apart; rxData sequence 0E, 01, FF.
- 5-cycle low glitch on idle line -> no rxReady, no framingError; rxBusy pulses high ≤ HALF cycles, then returns to IDLE.
- Frame 8'h55 with stop bit forced low, then line high -> framingError one pulse, rxReady none, rxData keeps previous value 8'h0A; next good frame 8'h10 received normally.
- Hold rx low 25 bit-times (BREAK_BITS=20) -> framingError once, lineBreak high from bit-time 20 until rx returns high, then 0.
- Assert reset for 1 cycle in the middle of data bit 4 of a frame -> all outputs return to reset values the next cycle; no strobe for the aborted frame; a following clean frame 8'hA5 gives rxData=8'hA5.

Source files
------------

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronizes the serial line, samples each bit at mid-bit
// and emits a one-cycle rxReady strobe with the received byte on rxData.
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BREAK_BITS   = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rxReady,
    output logic [7:0] rxData,
    output logic       framingError,
    output logic       lineBreak,
    output logic       rxBusy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(BREAK_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [BW-1:0] BRK_FULL = BW'(BREAK_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            ready_q, ready_d;
    logic            ferr_q, ferr_d;
    logic            brk_q, brk_d;
    logic [CW-1:0]   brk_cyc_q, brk_cyc_d;
    logic [BW-1:0]   brk_bits_q, brk_bits_d;

    always_comb begin
        rx_meta_d  = rx;
        rx_s_d     = rx_meta_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_d     = data_q;
        ready_d    = 1'b0;
        ferr_d     = 1'b0;
        brk_d      = 1'b0;
        brk_cyc_d  = brk_cyc_q;
        brk_bits_d = brk_bits_q;

        // Bit-times elapsed since the start edge, saturating once a break is reached
        if (state_q == IDLE) begin
            brk_cyc_d  = '0;
            brk_bits_d = '0;
        end else if (brk_bits_q != BRK_FULL) begin
            if (brk_cyc_q == CNT_LAST) begin
                brk_cyc_d  = '0;
                brk_bits_d = brk_bits_q + BW'(1);
            end else begin
                brk_cyc_d = brk_cyc_q + CW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d[bit_q] = rx_s_q;
                    cnt_d          = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch the next start edge
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        ready_d = 1'b1;
                        data_d  = shift_q;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end else begin
                    brk_d = (brk_bits_q == BRK_FULL);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            brk_cyc_q  <= '0;
            brk_bits_q <= '0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            brk_cyc_q  <= brk_cyc_d;
            brk_bits_q <= brk_bits_d;
        end
    end

    assign rxReady      = ready_q;
    assign rxData       = data_q;
    assign framingError = ferr_q;
    assign lineBreak    = brk_q;
    assign rxBusy       = (state_q != IDLE);

endmodule
